i2c_ball_tx_seq: RTL and testbench

Packet sequencer that sits directly upstream of the I2C master in the ball-handoff link between the two game boards. On a ball send trigger it snapshots ball state and emits the command stream START, address, 5 payload bytes, STOP through the master's byte-command handshake. It drives `is_transfer` for the game logic and buffers one pending request while a transfer is in flight.

---
 rtl/i2c_ball_tx_seq_pkg.sv | 48 ++++
 rtl/i2c_ball_tx_seq_if.sv | 20 ++
 rtl/i2c_ball_tx_seq_timeout.sv | 22 ++
 rtl/i2c_ball_tx_seq.sv | 210 +++++++++++++++++++++
 tb/tb_i2c_ball_tx_seq.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/i2c_ball_tx_seq_pkg.sv
// Shared types for the ball-handoff link: FSM states, ball snapshot, payload packing.
// The checksum states exist only when BALL_TX_CHECKSUM_EN is defined.
package ball_link_pkg;

  localparam int BALL_PAYLOAD_LEN = 5;

  typedef enum logic [3:0] {
    IDLE,
    CMD_START,
    WAIT_START,
    CMD_ADDR,
    WAIT_ADDR,
    CMD_DATA,
    WAIT_DATA,
`ifdef BALL_TX_CHECKSUM_EN
    CMD_CSUM,
    WAIT_CSUM,
`endif
    CMD_STOP,
    WAIT_STOP
  } tx_state_e;

  typedef struct packed {
    logic [9:0] y;
    logic [7:0] vy;
    logic [1:0] grav;
    logic       coll;
  } ball_pkt_t;

  // idx 0..4 are payload bytes; any other index yields their XOR
  function automatic logic [7:0] pack_byte(ball_pkt_t p, logic [2:0] idx);
    logic [7:0] b0, b1, b2, b3, b4;
    b0 = {6'b0, p.y[9:8]};
    b1 = p.y[7:0];
    b2 = p.vy;
    b3 = {6'b0, p.grav};
    b4 = {7'b0, p.coll};
    case (idx)
      3'd0:    return b0;
      3'd1:    return b1;
      3'd2:    return b2;
      3'd3:    return b3;
      3'd4:    return b4;
      default: return b0 ^ b1 ^ b2 ^ b3 ^ b4;
    endcase
  endfunction

endpackage

// File: rtl/i2c_ball_tx_seq_if.sv
// Byte-command handshake between the ball sequencer and the I2C master.
// Sequencer side is the master modport, I2C engine side the slave.
interface i2c_ball_tx_seq_if;
  logic       i2c_en;
  logic       start;
  logic       stop;
  logic [7:0] tx_data;
  logic       ready;
  logic       tx_done;

  modport master (
    output i2c_en, start, stop, tx_data,
    input  ready, tx_done
  );

  modport slave (
    input  i2c_en, start, stop, tx_data,
    output ready, tx_done
  );
endinterface

// File: rtl/i2c_ball_tx_seq_timeout.sv
// Per-command watchdog: counts enabled cycles, clear wins, expire at CYC-1.
module ball_tx_timeout #(
  parameter int CYC = 100_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);
  localparam int W = (CYC > 2) ? $clog2(CYC) : 1;

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 1'b1;
  end

  assign expire = en && (cnt == W'(CYC - 1));
endmodule

// File: rtl/i2c_ball_tx_seq.sv
// Ball-state packet sequencer: START, address, payload, STOP to the I2C master.
// Define BALL_TX_CHECKSUM_EN to append an XOR checksum byte.
import ball_link_pkg::*;

module i2c_ball_tx_seq #(
  parameter logic [6:0] SLV_ADDR    = 7'h3C,
  parameter int         TIMEOUT_CYC = 100_000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ball_send_trigger,
  input  logic [9:0]               ball_y,
  input  logic [7:0]               ball_vy,
  input  logic [1:0]               gravity_counter,
  input  logic                     is_collusion,
  i2c_ball_tx_seq_if.master        bus,
  output logic                     is_transfer,
  output logic                     tx_err
);
  localparam logic [7:0] ADDR_BYTE = {SLV_ADDR, 1'b0};
  localparam logic [2:0] LAST_IDX  = 3'(BALL_PAYLOAD_LEN - 1);

  tx_state_e  st, nxt, tgt;
  ball_pkt_t  cur, cur_n, pend, pend_n, snap;
  logic       pend_v, pv_n;
  logic [2:0] idx, idx_n;
  logic       trig_q, edge_r;
  logic       go, en_n, start_n, stop_n, err_n;
  logic [7:0] data_n;
  logic       in_wait, expire;

  assign snap = '{y: ball_y, vy: ball_vy,
                  grav: gravity_counter, coll: is_collusion};

  always_comb begin
    in_wait = st inside {WAIT_START, WAIT_ADDR, WAIT_DATA, WAIT_STOP};
`ifdef BALL_TX_CHECKSUM_EN
    in_wait = in_wait || (st == WAIT_CSUM);
`endif
  end

  ball_tx_timeout #(.CYC(TIMEOUT_CYC)) u_tmo (
    .clk    (clk),
    .reset  (reset),
    .clr    (en_n),
    .en     (in_wait),
    .expire (expire)
  );

  always_comb begin
    nxt     = st;
    tgt     = CMD_START;
    go      = 1'b0;
    en_n    = 1'b0;
    start_n = 1'b0;
    stop_n  = 1'b0;
    err_n   = 1'b0;
    data_n  = 8'h00;
    idx_n   = idx;
    cur_n   = cur;
    pend_n  = pend;
    pv_n    = pend_v;

    if (edge_r && st != IDLE) begin
      pend_n = snap;
      pv_n   = 1'b1;
    end

    case (st)
      IDLE: begin
        if (edge_r) begin
          cur_n = snap;
          go    = 1'b1;
        end else if (pend_v) begin
          cur_n = pend;
          pv_n  = 1'b0;
          go    = 1'b1;
        end
      end
`ifdef BALL_TX_CHECKSUM_EN
      CMD_CSUM,
`endif
      CMD_START, CMD_ADDR, CMD_DATA, CMD_STOP: begin
        go  = 1'b1;
        tgt = st;
      end
      WAIT_START: if (bus.tx_done) begin
        go  = 1'b1;
        tgt = CMD_ADDR;
      end
      WAIT_ADDR: if (bus.tx_done) begin
        go    = 1'b1;
        tgt   = CMD_DATA;
        idx_n = 3'd0;
      end
      WAIT_DATA: if (bus.tx_done) begin
        go = 1'b1;
        if (idx == LAST_IDX) begin
`ifdef BALL_TX_CHECKSUM_EN
          tgt = CMD_CSUM;
`else
          tgt = CMD_STOP;
`endif
        end else begin
          idx_n = idx + 3'd1;
          tgt   = CMD_DATA;
        end
      end
`ifdef BALL_TX_CHECKSUM_EN
      WAIT_CSUM: if (bus.tx_done) begin
        go  = 1'b1;
        tgt = CMD_STOP;
      end
`endif
      // a same-cycle trigger edge counts as a pending request
      WAIT_STOP: if (bus.tx_done) begin
        if (edge_r) begin
          cur_n = snap;
          pv_n  = 1'b0;
          go    = 1'b1;
        end else if (pend_v) begin
          cur_n = pend;
          pv_n  = 1'b0;
          go    = 1'b1;
        end else begin
          nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase

    if (in_wait && !bus.tx_done && expire) begin
      err_n = 1'b1;
      if (st == WAIT_STOP) begin
        nxt = IDLE;
      end else begin
        go  = 1'b1;
        tgt = CMD_STOP;
      end
    end

    // strobe is registered, so it is decided one cycle ahead
    if (go) begin
      nxt = tgt;
      if (bus.ready) begin
        en_n = 1'b1;
        case (tgt)
          CMD_START: begin
            nxt     = WAIT_START;
            start_n = 1'b1;
          end
          CMD_ADDR: begin
            nxt    = WAIT_ADDR;
            data_n = ADDR_BYTE;
          end
          CMD_DATA: begin
            nxt    = WAIT_DATA;
            data_n = pack_byte(cur_n, idx_n);
          end
`ifdef BALL_TX_CHECKSUM_EN
          CMD_CSUM: begin
            nxt    = WAIT_CSUM;
            data_n = pack_byte(cur_n, 3'd5);
          end
`endif
          CMD_STOP: begin
            nxt    = WAIT_STOP;
            stop_n = 1'b1;
          end
          default: begin
            nxt  = IDLE;
            en_n = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st          <= IDLE;
      cur         <= '0;
      pend        <= '0;
      pend_v      <= 1'b0;
      idx         <= 3'd0;
      trig_q      <= 1'b0;
      edge_r      <= 1'b0;
      bus.i2c_en  <= 1'b0;
      bus.start   <= 1'b0;
      bus.stop    <= 1'b0;
      bus.tx_data <= 8'h00;
      is_transfer <= 1'b0;
      tx_err      <= 1'b0;
    end else begin
      st          <= nxt;
      cur         <= cur_n;
      pend        <= pend_n;
      pend_v      <= pv_n;
      idx         <= idx_n;
      trig_q      <= ball_send_trigger;
      edge_r      <= ball_send_trigger & ~trig_q;
      bus.i2c_en  <= en_n;
      bus.start   <= start_n;
      bus.stop    <= stop_n;
      bus.tx_data <= data_n;
      is_transfer <= (nxt != IDLE);
      tx_err      <= err_n;
    end
  end
endmodule

// File: tb/tb_i2c_ball_tx_seq.sv
// Directed bench for i2c_ball_tx_seq with a simple I2C master model.
// Checksum frames are expected when BALL_TX_CHECKSUM_EN is defined.
module tb_i2c_ball_tx_seq;
  localparam int ACK = 20;
`ifdef BALL_TX_CHECKSUM_EN
  localparam int FLEN = 9;
`else
  localparam int FLEN = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       trig = 1'b0;
  logic [9:0] y = '0;
  logic [7:0] vy = '0;
  logic [1:0] grav = '0;
  logic       coll = 1'b0;
  logic       is_transfer, tx_err;
  logic       ready_block = 1'b0;
  logic       drop_en = 1'b0;
  logic       m_busy, m_hold;
  int         m_cnt;
  int         cyc = 0;

  int errors = 0;
  int checks = 0;
  int bad_idle = 0;
  int err_cnt = 0;
  logic [9:0] log_q[$];
  logic [9:0] exp_q[$];

  i2c_ball_tx_seq_if bus ();

  i2c_ball_tx_seq #(.SLV_ADDR(7'h3C), .TIMEOUT_CYC(64)) dut (
    .clk               (clk),
    .reset             (rst_n),
    .ball_send_trigger (trig),
    .ball_y            (y),
    .ball_vy           (vy),
    .gravity_counter   (grav),
    .is_collusion      (coll),
    .bus               (bus),
    .is_transfer       (is_transfer),
    .tx_err            (tx_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign bus.ready = !m_busy && !ready_block;

  // master model: completes each command ACK cycles after its strobe
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy      <= 1'b0;
      m_hold      <= 1'b0;
      m_cnt       <= 0;
      bus.tx_done <= 1'b0;
    end else begin
      bus.tx_done <= 1'b0;
      if (m_busy) begin
        if (tx_err) begin
          m_busy <= 1'b0;
        end else if (!m_hold) begin
          if (m_cnt == ACK - 1) begin
            m_busy      <= 1'b0;
            bus.tx_done <= 1'b1;
          end else begin
            m_cnt <= m_cnt + 1;
          end
        end
      end else if (bus.i2c_en) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
        m_hold <= drop_en && !bus.start && !bus.stop &&
                  bus.tx_data == 8'hF3;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (bus.i2c_en)
      log_q.push_back({bus.start, bus.stop, bus.tx_data});
    else if (bus.start || bus.stop || bus.tx_data != 8'h00)
      bad_idle++;
    if (tx_err) err_cnt++;
  endtask

  task automatic pulse(input logic [9:0] py, input logic [7:0] pvy,
                       input logic [1:0] pg, input logic pc);
    y = py; vy = pvy; grav = pg; coll = pc;
    trig = 1'b1;
    step();
    trig = 1'b0;
    step();
  endtask

  task automatic run_idle(input int max, input string tag);
    int n = 0;
    while (is_transfer && n < max) begin
      step();
      n++;
    end
    chk(tag, {31'd0, is_transfer}, 32'd0);
  endtask

  task automatic wait_stop(input int max, input string tag);
    int n = 0;
    while (!(bus.i2c_en && bus.stop) && n < max) begin
      step();
      n++;
    end
    chk(tag, {31'd0, bus.i2c_en && bus.stop}, 32'd1);
  endtask

  function automatic void push_frame(logic [9:0] fy, logic [7:0] fvy,
                                     logic [1:0] fg, logic fc);
    logic [7:0] b0, b3, b4;
    b0 = {6'b0, fy[9:8]};
    b3 = {6'b0, fg};
    b4 = {7'b0, fc};
    exp_q.push_back(10'h200);
    exp_q.push_back(10'h078);
    exp_q.push_back({2'b00, b0});
    exp_q.push_back({2'b00, fy[7:0]});
    exp_q.push_back({2'b00, fvy});
    exp_q.push_back({2'b00, b3});
    exp_q.push_back({2'b00, b4});
`ifdef BALL_TX_CHECKSUM_EN
    exp_q.push_back({2'b00, b0 ^ fy[7:0] ^ fvy ^ b3 ^ b4});
`endif
    exp_q.push_back(10'h100);
  endfunction

  task automatic chk_log(input string tag);
    int n;
    chk({tag, "_len"}, log_q.size(), exp_q.size());
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_%0d", tag, i), {22'd0, log_q[i]}, {22'd0, exp_q[i]});
    log_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int n;
    int s;
    step(); step(); step();
    chk("rst_en",   {31'd0, bus.i2c_en}, 32'd0);
    chk("rst_ss",   {30'd0, bus.start, bus.stop}, 32'd0);
    chk("rst_data", {24'd0, bus.tx_data}, 32'd0);
    chk("rst_xfer", {31'd0, is_transfer}, 32'd0);
    chk("rst_err",  {31'd0, tx_err}, 32'd0);
    rst_n = 1'b1;
    step(); step();

    // single frame with hand-computed bytes
    log_q.delete();
    y = 10'h2A5; vy = 8'hF3; grav = 2'd2; coll = 1'b1;
    trig = 1'b1;
    step();
    chk("f1_xfer_n1", {31'd0, is_transfer}, 32'd0);
    step();
    chk("f1_xfer_n2", {31'd0, is_transfer}, 32'd1);
    chk("f1_start_n2", {30'd0, bus.i2c_en, bus.start}, 32'd3);
    trig = 1'b0;
    wait_stop(500, "f1_stop_seen");
    n = 0;
    while (!bus.tx_done && n < 100) begin
      step();
      n++;
    end
    chk("f1_stop_done", {31'd0, bus.tx_done}, 32'd1);
    chk("f1_xfer_at_done", {31'd0, is_transfer}, 32'd1);
    step();
    chk("f1_xfer_fall", {31'd0, is_transfer}, 32'd0);
    exp_q.push_back(10'h200);
    exp_q.push_back(10'h078);
    exp_q.push_back(10'h002);
    exp_q.push_back(10'h0A5);
    exp_q.push_back(10'h0F3);
    exp_q.push_back(10'h002);
    exp_q.push_back(10'h001);
`ifdef BALL_TX_CHECKSUM_EN
    exp_q.push_back(10'h057);
`endif
    exp_q.push_back(10'h100);
    chk_log("f1");

    // two edges while busy: only the newest is sent, no gap
    pulse(10'd1, 8'h00, 2'd0, 1'b0);
    repeat (30) step();
    pulse(10'd5, 8'h00, 2'd0, 1'b0);
    repeat (10) step();
    pulse(10'd9, 8'h00, 2'd0, 1'b0);
    run_idle(3000, "pend_idle");
    repeat (30) step();
    chk("pend_count", log_q.size(), 2 * FLEN);
    push_frame(10'd1, 8'h00, 2'd0, 1'b0);
    push_frame(10'd9, 8'h00, 2'd0, 1'b0);
    chk_log("pend");

    // trigger edge coincident with the final STOP tx_done
    pulse(10'h111, 8'h80, 2'd1, 1'b1);
    wait_stop(500, "co_stop_seen");
    repeat (ACK) step();
    y = 10'h222; vy = 8'h7F; grav = 2'd3; coll = 1'b0;
    trig = 1'b1;
    step();
    chk("co_done", {31'd0, bus.tx_done}, 32'd1);
    chk("co_xfer_a", {31'd0, is_transfer}, 32'd1);
    step();
    trig = 1'b0;
    chk("co_xfer_b", {31'd0, is_transfer}, 32'd1);
    chk("co_restart", {30'd0, bus.i2c_en, bus.start}, 32'd3);
    run_idle(2000, "co_idle");
    push_frame(10'h111, 8'h80, 2'd1, 1'b1);
    push_frame(10'h222, 8'h7F, 2'd3, 1'b0);
    chk_log("co");

    // ready held low: no strobe, snapshot unaffected by later inputs
    ready_block = 1'b1;
    pulse(10'h100, 8'h7F, 2'd3, 1'b0);
    y = 10'h3FF; vy = 8'h11; grav = 2'd0; coll = 1'b1;
    repeat (48) step();
    chk("rdy_no_strobe", log_q.size(), 0);
    chk("rdy_xfer", {31'd0, is_transfer}, 32'd1);
    ready_block = 1'b0;
    step();
    chk("rdy_start", {30'd0, bus.i2c_en, bus.start}, 32'd3);
    run_idle(1000, "rdy_idle");
    push_frame(10'h100, 8'h7F, 2'd3, 1'b0);
    chk_log("rdy");

    // master withholds tx_done for B2
    err_cnt = 0;
    drop_en = 1'b1;
    pulse(10'h2A5, 8'hF3, 2'd2, 1'b1);
    n = 0;
    while (!(bus.i2c_en && bus.tx_data == 8'hF3) && n < 500) begin
      step();
      n++;
    end
    s = cyc;
    chk("to_b2_seen", {24'd0, bus.tx_data}, 32'hF3);
    n = 0;
    while (!tx_err && n < 200) begin
      step();
      n++;
    end
    chk("to_err_cycle", cyc - s, 64);
    step();
    chk("to_err_pulse", {31'd0, tx_err}, 32'd0);
    drop_en = 1'b0;
    wait_stop(50, "to_stop_seen");
    run_idle(200, "to_idle");
    chk("to_err_count", err_cnt, 1);
    exp_q.push_back(10'h200);
    exp_q.push_back(10'h078);
    exp_q.push_back(10'h002);
    exp_q.push_back(10'h0A5);
    exp_q.push_back(10'h0F3);
    exp_q.push_back(10'h100);
    chk_log("to");

    // reset in WAIT_DATA, then a clean frame
    pulse(10'h3C3, 8'h5A, 2'd1, 1'b0);
    n = 0;
    while (log_q.size() < 3 && n < 500) begin
      step();
      n++;
    end
    repeat (5) step();
    chk("mr_pre_xfer", {31'd0, is_transfer}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_outs", {20'd0, bus.i2c_en, bus.start, bus.stop, bus.tx_data,
                    is_transfer, tx_err}, 32'd0);
    step(); step(); step();
    chk("mr_hold", {31'd0, is_transfer}, 32'd0);
    rst_n = 1'b1;
    log_q.delete();
    step();
    pulse(10'h0C3, 8'hA5, 2'd2, 1'b1);
    run_idle(1000, "mr_idle");
    push_frame(10'h0C3, 8'hA5, 2'd2, 1'b1);
    chk_log("mr");

    chk("idle_zero", bad_idle, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
